// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencer (IDLE/RUN/HALTED) with relative/LUT branches.
// Optional macro FETCH_CYCLE_COUNT_EN adds a saturating RUN-cycle counter output.
`default_nettype none

module fetch_unit #(
   parameter int PC_W      = 8,
   parameter int LUT_IDX_W = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 halt,
   input  logic                 stall,
   input  logic                 branch_taken,
   input  logic                 branch_mode,
   input  logic [LUT_IDX_W-1:0] branch_operand,
   input  logic                 lut_wr_en,
   input  logic [LUT_IDX_W-1:0] lut_wr_idx,
   input  logic [PC_W-1:0]      lut_wr_data,
`ifdef FETCH_CYCLE_COUNT_EN
   output logic [15:0]          cycle_count,
`endif
   output logic [PC_W-1:0]      pc,
   output logic                 fetch_valid,
   output logic                 done
);

   localparam int LUT_N = 2 ** LUT_IDX_W;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_HALTED = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [PC_W-1:0]       pc_q, pc_d;
   logic                  fetch_valid_q, fetch_valid_d;
   logic                  done_q, done_d;
   logic [PC_W-1:0]       lut_q [LUT_N];
   logic [PC_W-1:0]       lut_d [LUT_N];
   logic signed [PC_W-1:0] rel_off;

   // Relative offsets are two's complement in the operand field.
   assign rel_off = PC_W'($signed(branch_operand));

   // Branch reads use lut_q, so a same-cycle write to that index is not yet visible.
   always_comb begin
      lut_d = lut_q;
      if (lut_wr_en) begin
         lut_d[lut_wr_idx] = lut_wr_data;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      unique case (state_q)
         S_IDLE: begin
            pc_d = '0;
            if (start) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (stall) begin
               pc_d = pc_q;
            end else if (halt) begin
               state_d = S_HALTED;
            end else if (branch_taken) begin
               pc_d = branch_mode ? lut_q[branch_operand] : pc_q + rel_off;
            end else begin
               pc_d = pc_q + PC_W'(1);
            end
         end
         S_HALTED: begin
            if (start) begin
               state_d = S_RUN;
               pc_d    = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            pc_d    = '0;
         end
      endcase
      fetch_valid_d = (state_d == S_RUN);
      done_d        = (state_d == S_HALTED);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         pc_q          <= '0;
         fetch_valid_q <= 1'b0;
         done_q        <= 1'b0;
         lut_q         <= '{default: '0};
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         fetch_valid_q <= fetch_valid_d;
         done_q        <= done_d;
         lut_q         <= lut_d;
      end
   end

   assign pc          = pc_q;
   assign fetch_valid = fetch_valid_q;
   assign done        = done_q;

`ifdef FETCH_CYCLE_COUNT_EN
   logic [15:0] cycle_count_q, cycle_count_d;

   // Counts every cycle spent in RUN (stalls included); restart clears it.
   always_comb begin
      cycle_count_d = cycle_count_q;
      if (state_q != S_RUN && state_d == S_RUN) begin
         cycle_count_d = '0;
      end else if (state_q == S_RUN && cycle_count_q != 16'hFFFF) begin
         cycle_count_d = cycle_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_count_q <= '0;
      end else begin
         cycle_count_q <= cycle_count_d;
      end
   end

   assign cycle_count = cycle_count_q;
`endif

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_W, default 8: program counter and LUT entry width.
REQ-002 Parameter LUT_IDX_W, default 5: branch LUT index width (2**LUT_IDX_W entries).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  begin program execution at pc=0.
REQ-006 halt  input  1  current instruction is the halt opcode (decoded downstream).
REQ-007 stall  input  1  hold pc this cycle.
REQ-008 branch_taken  input  1  redirect pc this cycle.
REQ-009 branch_mode  input  1  0 = relative offset, 1 = absolute via LUT.
REQ-010 branch_operand  input  LUT_IDX_W  signed offset (mode 0) or LUT index (mode 1).
REQ-011 lut_wr_en, lut_wr_idx, lut_wr_data  input  1 / LUT_IDX_W / PC_W  LUT write port.
REQ-012 pc  output  PC_W  instruction memory address.
REQ-013 fetch_valid  output  1  pc addresses a live instruction.
REQ-014 done  output  1  program has halted.

Function
REQ-015 States: IDLE, RUN, HALTED; encoding at implementer's discretion.
REQ-016 IDLE: pc=0, fetch_valid=0, done=0; start=1 -> RUN next cycle with pc=0.
REQ-017 RUN: fetch_valid=1, done=0; start ignored.
REQ-018 RUN priority per cycle: stall > halt > branch_taken > sequential.
REQ-019 stall=1: pc, state unchanged; halt/branch_taken ignored that cycle.
REQ-020 halt=1 (no stall): -> HALTED next cycle, pc holds current value.
REQ-021 branch_taken, mode 0: pc <= pc + sign_extend(branch_operand), modulo 2**PC_W (range -16..+15).
REQ-022 branch_taken, mode 1: pc <= lut[branch_operand].
REQ-023 Sequential: pc <= pc + 1; 255 wraps to 0, no flag.
REQ-024 HALTED: done=1, fetch_valid=0, pc frozen; start=1 -> RUN with pc=0, done=0 next cycle.
REQ-025 LUT writes accepted in every state; same-cycle write and mode-1 read of same index returns old entry.
REQ-026 Outputs are registered; pc change visible the cycle after the deciding inputs.

Reset
REQ-027 rst=1 on a clock edge: state=IDLE, pc=0, fetch_valid=0, done=0, all LUT entries=0.
REQ-028 rst wins over start, halt, branch and LUT write in the same cycle.
REQ-029 rst mid-RUN or mid-HALTED abandons execution; start required to rerun.

Configuration
REQ-030 Macro FETCH_CYCLE_COUNT_EN defined: adds output cycle_count (16 bits), incremented each RUN cycle including stalls, saturating at 0xFFFF, cleared by rst and on IDLE/HALTED->RUN, held in HALTED.
REQ-031 Macro undefined: cycle_count port and counter logic absent; all other behaviour identical.

Verification
REQ-032 rst 2 cycles, start 1 cycle, no branches, 4 cycles -> pc 0,1,2,3; fetch_valid=1; done=0.
REQ-033 Write lut[3]=0x40; at pc=5 branch_taken mode 1 operand 3 -> pc=0x40; at pc=0x40 mode 0 operand 5'b11110 -> pc=0x3E.
REQ-034 pc=0xFF sequential -> pc=0x00; pc=0x02 mode 0 operand -4 -> pc=0xFE.
REQ-035 stall+halt at pc=7 -> pc=7, RUN; next cycle halt only -> HALTED, done=1, pc=7; start -> pc=0, done=0.
REQ-036 rst asserted while in RUN at pc=0x20 -> pc=0, IDLE, done=0, lut reads 0.
REQ-037 With FETCH_CYCLE_COUNT_EN: start, 10 RUN cycles (2 stalled), halt -> cycle_count=10 held in HALTED; restart clears to 0.
